tx_pll_lock_supervisor: RTL

- Sequences bring-up of the transceiver TX PLL and its lane.
- Synchronises the PLL fabric lock and the lane-side lock, qualifies them as stable, and holds the lane in reset until lock is trustworthy.
- Retries on timeout, latches a fault after repeated failures, and re-runs the sequence on loss of lock.
- Sits in the fabric clock domain between the TX PLL wrapper and the lane/JESD reset logic.

---
 rtl/tx_pll_lock_supervisor_if.sv | 22 ++
 rtl/tx_pll_lock_supervisor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tx_pll_lock_supervisor_if.sv
// rtl/tx_pll_lock_supervisor_if.sv - lock inputs and status outputs of the TX PLL lock supervisor
interface tx_pll_lock_supervisor_if;
  logic       pll_lock;
  logic       lock;
  logic       force_relock;
  logic       lane_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  modport master (
    output pll_lock, lock, force_relock,
    input  lane_rst, ready, fault, retry_cnt, loss_cnt, state
  );

  modport slave (
    input  pll_lock, lock, force_relock,
    output lane_rst, ready, fault, retry_cnt, loss_cnt, state
  );
endinterface

// File: rtl/tx_pll_lock_supervisor.sv
// rtl/tx_pll_lock_supervisor.sv - TX PLL/lane bring-up sequencer with lock qualification, retry and fault
module tx_pll_lock_supervisor #(
  parameter int RST_PULSE_CYC = 16,
  parameter int STABLE_CYC    = 1024,
  parameter int TIMEOUT_CYC   = 65536,
  parameter int RELEASE_CYC   = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input logic                  clk,
  input logic                  rst,
  tx_pll_lock_supervisor_if.slave sup
);

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(RELEASE_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic [1:0]       pll_sync, lane_sync;
  logic             lock_ok;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic [7:0]       loss_q, loss_d;
  logic             lane_rst_q, ready_q, fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_sync  <= 2'b00;
      lane_sync <= 2'b00;
    end else begin
      pll_sync  <= {pll_sync[0], sup.pll_lock};
      lane_sync <= {lane_sync[0], sup.lock};
    end
  end

  assign lock_ok   = pll_sync[1] & lane_sync[1];
  assign retry_inc = retry_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST_HOLD;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      retry_q    <= 4'd0;
      loss_q     <= 8'd0;
      lane_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      lane_rst_q <= !(state_d == ST_RELEASE || state_d == ST_READY);
      ready_q    <= (state_d == ST_READY);
      fault_q    <= (state_d == ST_FAULT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (sup.force_relock) begin
      state_d = ST_RST_HOLD;
      cnt_d   = '0;
      tcnt_d  = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (cnt_q == RP_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            tcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          // The attempt timeout spans both states and wins over a completing stable window.
          if (tcnt_q == TO_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            tcnt_d  = '0;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_RST_HOLD;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
            if (state_q == ST_WAIT_LOCK) begin
              if (lock_ok) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
              end
            end else if (!lock_ok) begin
              state_d = ST_WAIT_LOCK;
              cnt_d   = '0;
            end else if (cnt_q == SB_LAST) begin
              state_d = ST_RELEASE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (!lock_ok) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
          end else if (cnt_q == RL_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (!lock_ok) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
            retry_d = 4'd0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign sup.lane_rst  = lane_rst_q;
  assign sup.ready     = ready_q;
  assign sup.fault     = fault_q;
  assign sup.retry_cnt = retry_q;
  assign sup.loss_cnt  = loss_q;
  assign sup.state     = state_q;

endmodule
